frame_capture: RTL and testbench
================================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 76800, meaning pixels per frame (320x240).
REQ-002 SHALL have parameter ADDR_W, default 17, meaning frame-buffer address width; NUM_PIXELS <= 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cam_vsync  input  1  camera vsync, already synchronised to clk; high between frames.
REQ-006 SHALL have port cam_href  input  1  camera line-valid, synchronised.
REQ-007 SHALL have port cam_valid  input  1  one-cycle strobe marking cam_data valid.
REQ-008 SHALL have port cam_data  input  8  camera byte, RGB444 (byte0 = xxxxRRRR, byte1 = GGGGBBBB).
REQ-009 SHALL have port capture_req  input  1  single-cycle request to capture the next full frame.
REQ-010 SHALL have port rd_address  input  ADDR_W  read address from image_sender.
REQ-011 SHALL have port rd_pixel  output  12  registered pixel {R,G,B} at rd_address.
REQ-012 SHALL have port frame_ready  output  1  a complete frame is held in the buffer.
REQ-013 SHALL have port busy  output  1  high while waiting for or capturing a frame.
REQ-014 SHALL have port frame_error  output  1  the last frame had a pixel count other than NUM_PIXELS.

Function
REQ-015 FSM states SHALL be IDLE, SYNC, ARMED, CAPTURE and DONE.
REQ-016 IDLE/DONE + capture_req -> SYNC; capture_req SHALL clear frame_ready and frame_error in the same transition.
REQ-017 SYNC -> ARMED on the first cycle cam_vsync=1, so a capture never starts mid-frame.
REQ-018 ARMED -> CAPTURE on the first cycle cam_vsync=0; the write address and byte phase SHALL be cleared to 0.
REQ-019 In CAPTURE, cam_valid with cam_href=1 and cam_vsync=0 SHALL toggle the byte phase; phase 0 latches cam_data[3:0].
REQ-020 On phase 1, the block SHALL write {latched[3:0], cam_data} to the RAM at the write address and increment the address.
REQ-021 Byte phase SHALL be forced to 0 whenever cam_href=0, so half-pixels at line end are discarded.
REQ-022 Writes with write address >= NUM_PIXELS SHALL be suppressed; the address saturates at NUM_PIXELS.
REQ-023 CAPTURE -> DONE on the cam_vsync rising edge; frame_error SHALL be set if the write address != NUM_PIXELS.
REQ-024 A cam_valid in the same cycle as the vsync rise SHALL be ignored.
REQ-025 DONE SHALL hold frame_ready=1 and must not write the RAM; image_sender reads while in DONE.
REQ-026 capture_req in SYNC, ARMED or CAPTURE SHALL be ignored.
REQ-027 busy SHALL be high exactly in SYNC, ARMED and CAPTURE.
REQ-028 Read latency SHALL be 1 cycle: rd_pixel is valid the cycle after rd_address is presented, in any state.
REQ-029 rd_address >= NUM_PIXELS SHALL return rd_pixel = 0.
REQ-030 Reads and writes SHALL be concurrent; a read of the location being written returns the old data.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, frame_ready=0, busy=0, frame_error=0, rd_pixel=0, write address 0 and byte phase 0.
REQ-032 Reset mid-capture SHALL abandon the frame; RAM contents are not cleared and are undefined after reset.

Structure
REQ-033 Package image_pkg SHALL hold PIXEL_W=12, the state enum type and default NUM_PIXELS/ADDR_W.
REQ-034 Sub-module frame_ram SHALL be a simple dual-port RAM (1 write port, 1 registered read port, NUM_PIXELS x 12) inferable as block RAM.

Verification (NUM_PIXELS=3 unless stated)
REQ-035 Pulse capture_req, vsync 1->0, send 3 pixels 0x0F,0x00 / 0x0F,0x00 / 0x0F,0x00 with href=1, then vsync rise -> frame_ready=1, frame_error=0, rd_address 0..2 returns 0xF00 one cycle later.
REQ-036 Capture only 2 pixels before vsync rise -> frame_ready=1, frame_error=1; capture 5 pixels -> addresses 0..2 hold the first 3 pixels and frame_error=1.
REQ-037 Pulse capture_req while cam_vsync=0 mid-frame -> stays SYNC/ARMED, busy=1, no writes until the next vsync high->low.
REQ-038 Send 1 byte, then href=0, then a full pixel 0x00,0x0F -> pixel 0 = 0x00F; the orphan byte is dropped.
REQ-039 Assert rst=0 mid-CAPTURE -> all outputs 0 asynchronously; a subsequent capture_req completes normally.
REQ-040 Second capture_req in DONE -> frame_ready drops next cycle; rd_address=3 always yields rd_pixel=0.

Source files
------------

// File: rtl/image_pkg.sv
// image_pkg: shared types and constants for the frame capture path.
//   PIXEL_W        - width of one stored pixel, {R[3:0], G[3:0], B[3:0]}
//   NUM_PIXELS_DEF - default pixels per frame (320x240)
//   ADDR_W_DEF     - default frame-buffer address width
//   cap_state_e    - capture FSM state encoding
package image_pkg;

  localparam int PIXEL_W        = 12;
  localparam int NUM_PIXELS_DEF = 76800;
  localparam int ADDR_W_DEF     = 17;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ARMED,
    CAPTURE,
    DONE
  } cap_state_e;

endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port frame buffer, NUM_PIXELS x PIXEL_W.
// One synchronous write port, one read port with a registered output
// (one cycle of latency). Out-of-range reads return 0, out-of-range
// writes are dropped. A read of the word being written returns the old
// contents. The array itself is not reset so it can map to block RAM;
// only the read register is cleared by reset.
//   clk_i      - clock
//   rst_ni     - async active-low reset (read register only)
//   we_i       - write enable
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address
//   rd_data_o  - registered read data
module frame_ram
  import image_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [PIXEL_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [PIXEL_W-1:0] rd_data_o
);

  // Index width just large enough for the array; the address ports may be
  // wider when NUM_PIXELS is not a power of two.
  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_PIXELS);

  logic [PIXEL_W-1:0] mem [NUM_PIXELS];
  logic               wr_ok;
  logic               rd_ok;
  logic [PIXEL_W-1:0] rd_q;

  assign wr_ok = {1'b0, wr_addr_i} < DEPTH;
  assign rd_ok = {1'b0, rd_addr_i} < DEPTH;

  always_ff @(posedge clk_i) begin
    if (we_i && wr_ok) mem[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rd_q <= '0;
    else if (rd_ok) rd_q <= mem[rd_addr_i[IDX_W-1:0]];
    else            rd_q <= '0;
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/frame_capture.sv
// frame_capture: grabs one complete RGB444 camera frame into a frame buffer
// on request and holds it for an image sender to read out.
//   clk          - system clock (single clock domain)
//   rst          - async active-low reset
//   cam_vsync    - camera vsync, synchronised; high between frames
//   cam_href     - camera line-valid, synchronised
//   cam_valid    - one-cycle strobe qualifying cam_data
//   cam_data     - camera byte: byte0 = xxxxRRRR, byte1 = GGGGBBBB
//   capture_req  - single-cycle request to capture the next full frame
//   rd_address   - frame-buffer read address
//   rd_pixel     - registered {R,G,B} at rd_address, one cycle later
//   frame_ready  - a complete frame is held in the buffer
//   busy         - waiting for or capturing a frame
//   frame_error  - last frame's pixel count differed from NUM_PIXELS
module frame_capture
  import image_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic               cam_valid,
  input  logic [7:0]         cam_data,
  input  logic               capture_req,
  input  logic [ADDR_W-1:0]  rd_address,
  output logic [PIXEL_W-1:0] rd_pixel,
  output logic               frame_ready,
  output logic               busy,
  output logic               frame_error
);

  // One extra bit so the saturated write address can reach NUM_PIXELS
  // even when NUM_PIXELS == 2**ADDR_W.
  localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(NUM_PIXELS);

  cap_state_e       state_q;
  logic [ADDR_W:0]  waddr_q;
  logic             phase_q;   // 0: expecting byte0, 1: expecting byte1
  logic [3:0]       red_q;     // red nibble held from byte0
  logic             ovf_q;     // a pixel arrived after the buffer was full
  logic             ready_q;
  logic             busy_q;
  logic             err_q;

  logic             byte_stb;
  logic             room;
  logic             ram_we;

  // A byte counts only inside a line and outside vsync; this also drops a
  // strobe coinciding with the vsync rise that ends the frame.
  assign byte_stb = (state_q == CAPTURE) && !cam_vsync && cam_href && cam_valid;
  assign room     = waddr_q < NPIX;
  assign ram_we   = byte_stb && phase_q && room;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      phase_q <= 1'b0;
      red_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (capture_req) begin
            state_q <= SYNC;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        // Wait for a vsync high so a capture never begins mid-frame.
        SYNC: begin
          if (cam_vsync) state_q <= ARMED;
        end
        ARMED: begin
          if (!cam_vsync) begin
            state_q <= CAPTURE;
            waddr_q <= '0;
            phase_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (cam_vsync) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            phase_q <= 1'b0;
            // The address saturates, so a long frame is caught by ovf_q.
            err_q   <= (waddr_q != NPIX) || ovf_q;
          end else if (!cam_href) begin
            // Drop any half pixel left at the end of a line.
            phase_q <= 1'b0;
          end else if (cam_valid) begin
            phase_q <= !phase_q;
            if (!phase_q)  red_q   <= cam_data[3:0];
            else if (room) waddr_q <= waddr_q + 1'b1;
            else           ovf_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign frame_error = err_q;

  frame_ram #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_i      (ram_we),
    .wr_addr_i (waddr_q[ADDR_W-1:0]),
    .wr_data_i ({red_q, cam_data}),
    .rd_addr_i (rd_address),
    .rd_data_o (rd_pixel)
  );

endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: directed sequence with randomized pixel data, checked
// against a frame-level model (lines of bytes -> pixels -> buffer words).
module tb_frame_capture;

  localparam int NP = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cam_vsync = 1'b1;
  logic          cam_href = 1'b0;
  logic          cam_valid = 1'b0;
  logic [7:0]    cam_data = '0;
  logic          capture_req = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic [11:0]   rd_pixel;
  logic          frame_ready;
  logic          busy;
  logic          frame_error;

  frame_capture #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_valid   (cam_valid),
    .cam_data    (cam_data),
    .capture_req (capture_req),
    .rd_address  (rd_address),
    .rd_pixel    (rd_pixel),
    .frame_ready (frame_ready),
    .busy        (busy),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  logic [11:0] mdl [NP];   // expected frame-buffer contents
  int          cnt;        // whole pixels received in the current frame
  bit          exp_err;
  logic [7:0]  lq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each line yields floor(bytes/2) pixels of {byte0[3:0], byte1}; only the
  // first NP pixels of a frame land in the buffer.
  function automatic void model_line(input logic [7:0] b[$]);
    for (int k = 0; k + 1 < b.size(); k += 2) begin
      if (cnt < NP) mdl[cnt] = {b[k][3:0], b[k+1]};
      cnt++;
    end
  endfunction

  task automatic send_line(input logic [7:0] b[$]);
    cam_href = 1'b1;
    tick();
    foreach (b[i]) begin
      if ($urandom_range(0, 1) == 1) tick();
      cam_data  = b[i];
      cam_valid = 1'b1;
      tick();
      cam_valid = 1'b0;
    end
    cam_href = 1'b0;
    tick();
  endtask

  task automatic open_frame();
    cam_vsync = 1'b1;
    tick();
    tick();
    cam_vsync = 1'b0;
    tick();
    cnt = 0;
  endtask

  // glitch: a byte0 then a byte1 strobe on the very cycle vsync rises; the
  // second one must not complete a pixel.
  task automatic close_frame(input bit glitch);
    if (glitch) begin
      cam_href  = 1'b1;
      cam_data  = 8'($urandom);
      cam_valid = 1'b1;
      tick();
      cam_data  = 8'($urandom);
      cam_vsync = 1'b1;
      tick();
      cam_valid = 1'b0;
      cam_href  = 1'b0;
    end else begin
      cam_vsync = 1'b1;
      tick();
    end
    exp_err = (cnt != NP);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_ready"}, 32'(frame_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_err"},   32'(frame_error), 32'(exp_err));
    for (int a = 0; a < 4; a++) begin
      rd_address = AW'(a);
      tick();
      chk($sformatf("%s_rd%0d", tag, a), 32'(rd_pixel), (a < NP) ? 32'(mdl[a]) : 32'd0);
    end
  endtask

  task automatic start_cap(input string tag);
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    chk({tag, "_busy"},  32'(busy),        32'd1);
    chk({tag, "_ready"}, 32'(frame_ready), 32'd0);
    chk({tag, "_err"},   32'(frame_error), 32'd0);
  endtask

  task automatic rand_frame(input int npix, input bit orphans, input bit glitch);
    int          rem;
    int          k;
    logic [31:0] r;
    open_frame();
    rem = npix;
    while (rem > 0) begin
      k = $urandom_range(1, 2);
      if (k > rem) k = rem;
      lq.delete();
      for (int j = 0; j < k; j++) begin
        r = $urandom;
        lq.push_back(r[15:8]);
        lq.push_back(r[7:0]);
      end
      if (orphans && $urandom_range(0, 1) == 1) lq.push_back(8'($urandom));
      send_line(lq);
      model_line(lq);
      rem -= k;
    end
    close_frame(glitch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_ready", 32'(frame_ready), 32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_err",   32'(frame_error), 32'd0);
    chk("rst_pix",   32'(rd_pixel),    32'd0);
    rst = 1'b1;
    tick();

    // directed: three 0xF00 pixels in one line
    start_cap("req_f00");
    open_frame();
    lq.delete();
    repeat (3) begin
      lq.push_back(8'h0F);
      lq.push_back(8'h00);
    end
    send_line(lq);
    model_line(lq);
    close_frame(1'b0);
    check_done("f00");

    // random full frames, split into lines, with orphan bytes
    for (int f = 0; f < 4; f++) begin
      start_cap($sformatf("req_r%0d", f));
      rand_frame(NP, 1'b1, 1'(f % 2));
      check_done($sformatf("full%0d", f));
    end

    // short frame, with a strobe on the vsync rise
    start_cap("req_short");
    rand_frame(2, 1'b0, 1'b1);
    check_done("short");

    // long frame: only the first NP pixels kept
    start_cap("req_long");
    rand_frame(5, 1'b1, 1'b0);
    check_done("long");

    // request arriving mid-frame: nothing written until next vsync cycle
    cam_vsync = 1'b0;
    tick();
    start_cap("req_mid");
    lq.delete();
    repeat (3) begin
      lq.push_back(8'($urandom));
      lq.push_back(8'($urandom));
    end
    send_line(lq);
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    chk("mid_busy",  32'(busy),        32'd1);
    chk("mid_ready", 32'(frame_ready), 32'd0);
    for (int a = 0; a < NP; a++) begin
      rd_address = AW'(a);
      tick();
      chk($sformatf("mid_keep%0d", a), 32'(rd_pixel), 32'(mdl[a]));
    end
    rand_frame(NP, 1'b0, 1'b0);
    check_done("mid");

    // orphan byte followed by a new line: phase restarts at byte0
    start_cap("req_orph");
    open_frame();
    lq.delete();
    lq.push_back(8'h05);
    send_line(lq);
    model_line(lq);
    lq.delete();
    lq.push_back(8'h00);
    lq.push_back(8'h0F);
    lq.push_back(8'($urandom));
    lq.push_back(8'($urandom));
    lq.push_back(8'($urandom));
    lq.push_back(8'($urandom));
    send_line(lq);
    model_line(lq);
    close_frame(1'b0);
    check_done("orph");

    // async reset in the middle of a capture
    rd_address = AW'(1);
    start_cap("req_rst");
    open_frame();
    lq.delete();
    lq.push_back(8'($urandom));
    lq.push_back(8'($urandom));
    send_line(lq);
    chk("cap_busy",   32'(busy),     32'd1);
    chk("cap_rd_old", 32'(rd_pixel), 32'(mdl[1]));
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", 32'(frame_ready), 32'd0);
    chk("arst_busy",  32'(busy),        32'd0);
    chk("arst_err",   32'(frame_error), 32'd0);
    chk("arst_pix",   32'(rd_pixel),    32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    start_cap("req_after");
    rand_frame(NP, 1'b1, 1'b1);
    check_done("after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
